// File: rtl/alu_regfile_pipe.sv
// Pipelined ALU with an internal register file: one-cycle execute stage for
// most ops, iterative restoring divider that stalls issue while it runs.
module alu_regfile_pipe #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  localparam int ADDR_W = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [ADDR_W-1:0] in_rs1,
  input  logic [ADDR_W-1:0] in_rs2,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_wb,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_result,
  output logic [ADDR_W-1:0] out_rd,
  output logic              out_divz,
  output logic              busy
);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpMul = 3'b010;
  localparam logic [2:0] OpDiv = 3'b011;
  localparam logic [2:0] OpAnd = 3'b100;
  localparam logic [2:0] OpNot = 3'b101;
  localparam logic [2:0] OpOr  = 3'b110;
  localparam logic [2:0] OpXor = 3'b111;

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {StIdle, StExec, StDiv} state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [2:0]        exOp_q;
  logic [DATA_W-1:0] exA_q, exB_q;
  logic [ADDR_W-1:0] exRd_q;
  logic              exWb_q;
  logic [DATA_W-1:0] rem_q, quo_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              outValid_q;
  logic [DATA_W-1:0] outResult_q;
  logic [ADDR_W-1:0] outRd_q;
  logic              outDivz_q;

  logic              accept;
  logic              resFire;
  logic [DATA_W-1:0] resValue;
  logic              resDivz;
  logic [DATA_W-1:0] aluResult;
  logic              aluDivz;
  logic [DATA_W-1:0] opA, opB;
  logic              newDivNz;
  logic [DATA_W:0]   divShift, divDiff;
  logic              divBit;
  logic [DATA_W-1:0] remNext, quoNext;

  assign in_ready   = (state_q != StDiv);
  assign busy       = (state_q != StIdle);
  assign accept     = in_valid && in_ready;
  assign out_valid  = outValid_q;
  assign out_result = outResult_q;
  assign out_rd     = outRd_q;
  assign out_divz   = outDivz_q;

  // Operand read bypasses the register file when the completing result targets it.
  assign opA = (resFire && exWb_q && (exRd_q == in_rs1)) ? resValue : regs_q[in_rs1];
  assign opB = (resFire && exWb_q && (exRd_q == in_rs2)) ? resValue : regs_q[in_rs2];
  assign newDivNz = (in_op == OpDiv) && (opB != '0);

  // One restoring shift-subtract step; quo_q shifts dividend bits out as quotient bits shift in.
  assign divShift = {rem_q, quo_q[DATA_W-1]};
  assign divDiff  = divShift - {1'b0, exB_q};
  assign divBit   = ~divDiff[DATA_W];
  assign remNext  = divBit ? divDiff[DATA_W-1:0] : divShift[DATA_W-1:0];
  assign quoNext  = {quo_q[DATA_W-2:0], divBit};

  always_comb begin
    aluResult = '0;
    aluDivz   = 1'b0;
    case (exOp_q)
      OpAdd: aluResult = exA_q + exB_q;
      OpSub: aluResult = exA_q - exB_q;
      OpMul: aluResult = exA_q * exB_q;
      OpDiv: begin
        aluResult = '1;
        aluDivz   = 1'b1;
      end
      OpAnd: aluResult = exA_q & exB_q;
      OpNot: aluResult = ~exA_q;
      OpOr:  aluResult = exA_q | exB_q;
      OpXor: aluResult = exA_q ^ exB_q;
      default: aluResult = '0;
    endcase
  end

  always_comb begin
    resFire  = 1'b0;
    resValue = aluResult;
    resDivz  = aluDivz;
    if (state_q == StExec) begin
      resFire = 1'b1;
    end else if ((state_q == StDiv) && (cnt_q == CntLast)) begin
      resFire  = 1'b1;
      resValue = quoNext;
      resDivz  = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StDiv: if (cnt_q == CntLast) state_d = StIdle;
      default: begin
        if (accept) state_d = newDivNz ? StDiv : StExec;
        else        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state_q <= StIdle;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      exOp_q      <= '0;
      exA_q       <= '0;
      exB_q       <= '0;
      exRd_q      <= '0;
      exWb_q      <= 1'b0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      outValid_q  <= 1'b0;
      outResult_q <= '0;
      outRd_q     <= '0;
      outDivz_q   <= 1'b0;
    end else begin
      if (accept) begin
        exOp_q <= in_op;
        exA_q  <= opA;
        exB_q  <= opB;
        exRd_q <= in_rd;
        exWb_q <= in_wb;
        rem_q  <= '0;
        quo_q  <= opA;
        cnt_q  <= '0;
      end else if (state_q == StDiv) begin
        rem_q <= remNext;
        quo_q <= quoNext;
        cnt_q <= cnt_q + CNT_W'(1);
      end
      outValid_q <= resFire;
      if (resFire) begin
        outResult_q <= resValue;
        outRd_q     <= exRd_q;
        outDivz_q   <= resDivz;
      end
    end
  end

  // Writeback is applied after the load so it wins on an address collision.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      if (ld_en) regs_q[ld_addr] <= ld_data;
      if (resFire && exWb_q) regs_q[exRd_q] <= resValue;
    end
  end

endmodule

// File: tb/tb_alu_regfile_pipe.sv
// Directed self-checking bench for alu_regfile_pipe (DATA_W=32, NREG=32).
module tb_alu_regfile_pipe;

  localparam int DW = 32;
  localparam int AW = 5;

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpMul = 3'b010;
  localparam logic [2:0] OpDiv = 3'b011;
  localparam logic [2:0] OpAnd = 3'b100;
  localparam logic [2:0] OpNot = 3'b101;
  localparam logic [2:0] OpOr  = 3'b110;
  localparam logic [2:0] OpXor = 3'b111;

  logic          clk = 1'b0;
  logic          clr;
  logic          in_valid, in_ready, in_wb;
  logic [2:0]    in_op;
  logic [AW-1:0] in_rs1, in_rs2, in_rd;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          out_valid, out_divz, busy;
  logic [DW-1:0] out_result;
  logic [AW-1:0] out_rd;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_regfile_pipe #(.DATA_W(DW), .NREG(32)) dut (
    .clk(clk), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_wb(in_wb),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .out_valid(out_valid), .out_result(out_result), .out_rd(out_rd),
    .out_divz(out_divz), .busy(busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] op, input int rs1, input int rs2, input int rd, input logic wb);
    in_valid = 1'b1;
    in_op    = op;
    in_rs1   = AW'(rs1);
    in_rs2   = AW'(rs2);
    in_rd    = AW'(rd);
    in_wb    = wb;
  endtask

  task automatic loadReg(input int a, input logic [DW-1:0] d);
    ld_en   = 1'b1;
    ld_addr = AW'(a);
    ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  // Reads a register back by issuing "or rX,rX" without writeback.
  task automatic readReg(input int r, input logic [DW-1:0] exp, input string tag);
    applyStimulus(OpOr, r, r, 0, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    checkOutput({tag, "_valid"}, DW'(out_valid), DW'(1));
    checkOutput(tag, out_result, exp);
  endtask

  initial begin
    logic sawPulse;
    clr = 1'b0; in_valid = 1'b0; in_op = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    in_wb = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (2) tick();
    checkOutput("rst_out_valid", DW'(out_valid), DW'(0));
    checkOutput("rst_out_result", out_result, DW'(0));
    checkOutput("rst_out_rd", DW'(out_rd), DW'(0));
    checkOutput("rst_out_divz", DW'(out_divz), DW'(0));
    checkOutput("rst_busy", DW'(busy), DW'(0));
    checkOutput("rst_in_ready", DW'(in_ready), DW'(1));
    clr = 1'b1;
    tick();

    // Back-to-back add then sub; the sub forwards r3 from the add.
    loadReg(1, 7);
    loadReg(2, 5);
    applyStimulus(OpAdd, 1, 2, 3, 1'b1);
    tick();
    applyStimulus(OpSub, 3, 2, 4, 1'b1);
    tick();
    checkOutput("add_valid", DW'(out_valid), DW'(1));
    checkOutput("add_result", out_result, DW'(12));
    checkOutput("add_rd", DW'(out_rd), DW'(3));
    in_valid = 1'b0;
    tick();
    checkOutput("sub_fwd_result", out_result, DW'(7));
    checkOutput("sub_rd", DW'(out_rd), DW'(4));
    checkOutput("sub_divz", DW'(out_divz), DW'(0));
    tick();
    checkOutput("pulse_end", DW'(out_valid), DW'(0));
    checkOutput("hold_result", out_result, DW'(7));
    readReg(4, DW'(7), "r4");

    // Wrap-around arithmetic at full width, wb=0 into r9.
    loadReg(1, 32'hFFFF_FFFF);
    loadReg(2, 32'd2);
    applyStimulus(OpAdd, 1, 2, 9, 1'b0);
    tick();
    applyStimulus(OpMul, 1, 2, 9, 1'b0);
    tick();
    checkOutput("add_wrap", out_result, 32'h0000_0001);
    applyStimulus(OpNot, 1, 2, 9, 1'b0);
    tick();
    checkOutput("mul_low", out_result, 32'hFFFF_FFFE);
    applyStimulus(OpSub, 2, 1, 9, 1'b0);
    tick();
    checkOutput("not_r1", out_result, 32'h0000_0000);
    in_valid = 1'b0;
    tick();
    checkOutput("sub_wrap", out_result, 32'h0000_0003);
    readReg(9, DW'(0), "r9_nowb");

    loadReg(1, 32'hF0F0_00FF);
    loadReg(2, 32'h0FF0_0F0F);
    applyStimulus(OpAnd, 1, 2, 0, 1'b0);
    tick();
    applyStimulus(OpOr, 1, 2, 0, 1'b0);
    tick();
    checkOutput("and", out_result, 32'h00F0_000F);
    applyStimulus(OpXor, 1, 2, 0, 1'b0);
    tick();
    checkOutput("or", out_result, 32'hFFF0_0FFF);
    in_valid = 1'b0;
    tick();
    checkOutput("xor", out_result, 32'hFF00_0FF0);

    // 100/7 with a dependent add held on in_valid throughout the stall.
    loadReg(1, 32'd100);
    loadReg(2, 32'd7);
    applyStimulus(OpDiv, 1, 2, 5, 1'b1);
    tick();
    applyStimulus(OpAdd, 5, 5, 10, 1'b1);
    checkOutput("div_ready_low", DW'(in_ready), DW'(0));
    checkOutput("div_busy", DW'(busy), DW'(1));
    for (int i = 1; i < 32; i++) begin
      tick();
      checkOutput("div_stall_ready", DW'(in_ready), DW'(0));
      checkOutput("div_no_pulse", DW'(out_valid), DW'(0));
    end
    tick();
    checkOutput("div_valid", DW'(out_valid), DW'(1));
    checkOutput("div_result", out_result, DW'(14));
    checkOutput("div_divz", DW'(out_divz), DW'(0));
    checkOutput("div_rd", DW'(out_rd), DW'(5));
    checkOutput("div_ready_back", DW'(in_ready), DW'(1));
    tick();
    checkOutput("div_single_pulse", DW'(out_valid), DW'(0));
    in_valid = 1'b0;
    tick();
    checkOutput("post_div_valid", DW'(out_valid), DW'(1));
    checkOutput("post_div_add", out_result, DW'(28));
    checkOutput("post_div_rd", DW'(out_rd), DW'(10));

    // Divide by zero finishes in one cycle.
    loadReg(2, 32'd0);
    applyStimulus(OpDiv, 1, 2, 6, 1'b1);
    tick();
    in_valid = 1'b0;
    checkOutput("divz_ready", DW'(in_ready), DW'(1));
    tick();
    checkOutput("divz_valid", DW'(out_valid), DW'(1));
    checkOutput("divz_result", out_result, 32'hFFFF_FFFF);
    checkOutput("divz_flag", DW'(out_divz), DW'(1));
    checkOutput("divz_rd", DW'(out_rd), DW'(6));
    readReg(6, 32'hFFFF_FFFF, "r6");

    // Writeback and load colliding on r3, then on different addresses.
    loadReg(1, 32'd4);
    loadReg(2, 32'd5);
    loadReg(3, 32'd0);
    applyStimulus(OpAdd, 1, 2, 3, 1'b1);
    tick();
    in_valid = 1'b0;
    loadReg(3, 32'h55);
    readReg(3, DW'(9), "wb_wins_r3");
    loadReg(3, 32'd0);
    applyStimulus(OpAdd, 1, 2, 3, 1'b1);
    tick();
    in_valid = 1'b0;
    loadReg(8, 32'h55);
    readReg(3, DW'(9), "both_r3");
    readReg(8, DW'(32'h55), "both_r8");

    // Asynchronous reset in the middle of a divide.
    loadReg(1, 32'd100);
    loadReg(2, 32'd7);
    applyStimulus(OpDiv, 1, 2, 5, 1'b1);
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    checkOutput("mid_div_busy", DW'(busy), DW'(1));
    clr = 1'b0;
    #1;
    checkOutput("arst_valid", DW'(out_valid), DW'(0));
    checkOutput("arst_busy", DW'(busy), DW'(0));
    checkOutput("arst_ready", DW'(in_ready), DW'(1));
    checkOutput("arst_result", out_result, DW'(0));
    tick();
    clr = 1'b1;
    sawPulse = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      sawPulse = sawPulse | out_valid;
    end
    checkOutput("arst_no_pulse", DW'(sawPulse), DW'(0));
    readReg(1, DW'(0), "arst_r1");
    readReg(5, DW'(0), "arst_r5");
    readReg(8, DW'(0), "arst_r8");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
